ifetch_prefetch_buf: RTL and testbench

Instruction prefetch stage between the instruction bus and the IF/ID pipeline register. Issues sequential word fetches, buffers returned instructions with their PCs in a small FIFO, and presents the head entry to the IF/ID register. Absorbs bus latency and IF/ID hold stalls, and discards stale fetches on a jump or flush.

---
 rtl/ifetch_prefetch_buf_pkg.sv | 14 +
 rtl/ifetch_prefetch_buf_if.sv | 32 +++
 rtl/ifetch_prefetch_buf_chk.sv | 24 ++
 rtl/ifetch_prefetch_buf_fifo.sv | 52 +++++
 rtl/ifetch_prefetch_buf.sv | 86 ++++++++
 tb/tb_ifetch_prefetch_buf.sv | 256 +++++++++++++++++++++++++
 6 files changed

// File: rtl/ifetch_prefetch_buf_pkg.sv
// Shared fetch-path definitions so the prefetch buffer and the IF/ID register
// agree on widths, the bubble instruction and the zero word.
package ifetch_prefetch_buf_pkg;

    localparam int unsigned IF_AW = 32;
    localparam int unsigned IF_DW = 32;

    localparam logic [IF_DW-1:0] IF_NOP_INST  = 32'h0000_0001;
    localparam logic [IF_AW-1:0] IF_ZERO_WORD = 32'h0000_0000;

    // Byte distance between consecutive sequential fetches.
    localparam logic [IF_AW-1:0] IF_PC_STEP = 32'h0000_0004;

endpackage

// File: rtl/ifetch_prefetch_buf_if.sv
// Fetch-side bundle: instruction bus handshake, redirect/stall controls and
// the head-of-buffer view presented to the IF/ID register.
interface ifetch_prefetch_buf_if
    import ifetch_prefetch_buf_pkg::*;
#(
    parameter int unsigned AW = IF_AW,
    parameter int unsigned DW = IF_DW
) ();

    logic          flush_i;
    logic [AW-1:0] flush_addr_i;
    logic          hold_i;
    logic          req_o;
    logic [AW-1:0] addr_o;
    logic          gnt_i;
    logic          rvalid_i;
    logic [DW-1:0] rdata_i;
    logic          inst_valid_o;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] inst_addr_o;

    modport master (
        input  flush_i, flush_addr_i, hold_i, gnt_i, rvalid_i, rdata_i,
        output req_o, addr_o, inst_valid_o, inst_o, inst_addr_o
    );

    modport slave (
        output flush_i, flush_addr_i, hold_i, gnt_i, rvalid_i, rdata_i,
        input  req_o, addr_o, inst_valid_o, inst_o, inst_addr_o
    );

endinterface

// File: rtl/ifetch_prefetch_buf_chk.sv
// Bus protocol checker for the prefetch stage: a response must always have an
// earlier grant outstanding (flushes do not change the outstanding total).
module ifetch_prefetch_buf_chk (
    input logic clk,
    input logic rst,
    input logic req,
    input logic gnt,
    input logic rvalid
);

    logic [7:0] outst_r;

    // Track granted-but-unanswered requests and flag orphan responses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outst_r <= 8'd0;
        end else begin
            assert (!(rvalid && (outst_r == 8'd0)))
                else $error("ifetch protocol violation: rvalid with no outstanding grant");
            outst_r <= outst_r + 8'(req && gnt) - 8'(rvalid);
        end
    end

endmodule

// File: rtl/ifetch_prefetch_buf_fifo.sv
// Small synchronous FIFO holding {pc, instruction} entries; head is read
// combinationally from registered storage so a push is visible next cycle.
module ifetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Pointer and occupancy tracking; clear wins over any push/pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + PW'(push);
            rd_ptr_r <= rd_ptr_r + PW'(pop);
            count_r  <= count_r + CW'(push) - CW'(pop);
        end
    end

    // Entry storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign count = count_r;

endmodule

// File: rtl/ifetch_prefetch_buf.sv
// Instruction prefetch stage: issues sequential fetches, buffers responses
// with their PCs, and drops responses that belong to fetches issued pre-flush.
module ifetch_prefetch_buf
    import ifetch_prefetch_buf_pkg::*;
#(
    parameter int unsigned   DEPTH    = 4,
    parameter int unsigned   AW       = IF_AW,
    parameter int unsigned   DW       = IF_DW,
    parameter logic [AW-1:0] RESET_PC = IF_ZERO_WORD,
    parameter logic [DW-1:0] NOP_INST = IF_NOP_INST
) (
    input  logic                 clk,
    input  logic                 rst,
    ifetch_prefetch_buf_if.master bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 2;

    logic [AW-1:0]    fetch_pc_r;
    logic [AW-1:0]    resp_pc_r;
    logic [CW-1:0]    pend_r;
    logic [CW-1:0]    disc_r;

    logic [CW-1:0]    count_s;
    logic [SW-1:0]    inflight_s;
    logic             req_s;
    logic             grant_s;
    logic             keep_s;
    logic             drop_s;
    logic             push_s;
    logic             pop_s;
    logic             head_valid_s;
    logic [AW+DW-1:0] head_s;

    // Discarded fetches still occupy a slot until their response returns.
    assign inflight_s   = SW'(count_s) + SW'(pend_r) + SW'(disc_r);
    assign req_s        = rst && !bus.flush_i && (inflight_s < SW'(DEPTH));
    assign grant_s      = req_s && bus.gnt_i;
    assign keep_s       = bus.rvalid_i && (disc_r == {CW{1'b0}});
    assign drop_s       = bus.rvalid_i && (disc_r != {CW{1'b0}});
    assign head_valid_s = (count_s != {CW{1'b0}});
    assign push_s       = keep_s && !bus.flush_i;
    assign pop_s        = head_valid_s && !bus.hold_i && !bus.flush_i;

    // Fetch PC, next kept-response PC and the outstanding-request counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            resp_pc_r  <= RESET_PC;
            pend_r     <= {CW{1'b0}};
            disc_r     <= {CW{1'b0}};
        end else if (bus.flush_i) begin
            fetch_pc_r <= bus.flush_addr_i;
            resp_pc_r  <= bus.flush_addr_i;
            disc_r     <= disc_r + pend_r - CW'(bus.rvalid_i);
            pend_r     <= {CW{1'b0}};
        end else begin
            fetch_pc_r <= grant_s ? fetch_pc_r + AW'(IF_PC_STEP) : fetch_pc_r;
            resp_pc_r  <= keep_s ? resp_pc_r + AW'(IF_PC_STEP) : resp_pc_r;
            pend_r     <= pend_r + CW'(grant_s) - CW'(keep_s);
            disc_r     <= disc_r - CW'(drop_s);
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush_i),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({resp_pc_r, bus.rdata_i}),
        .rdata (head_s),
        .count (count_s)
    );

    assign bus.req_o        = req_s;
    assign bus.addr_o       = fetch_pc_r;
    assign bus.inst_valid_o = head_valid_s;
    assign bus.inst_o       = head_valid_s ? head_s[DW-1:0] : NOP_INST;
    assign bus.inst_addr_o  = head_valid_s ? head_s[AW+DW-1:DW] : {AW{1'b0}};

endmodule

// File: tb/tb_ifetch_prefetch_buf.sv
// Directed bench for ifetch_prefetch_buf: a latency-configurable bus model and
// a scoreboard of expected {pc, inst} entries checked every cycle.
module tb_ifetch_prefetch_buf;
    import ifetch_prefetch_buf_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0001;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } resp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    ifetch_prefetch_buf_if #(.AW(AW), .DW(DW)) bus ();

    ifetch_prefetch_buf #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .DW       (DW),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ifetch_prefetch_buf_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req_o),
        .gnt    (bus.gnt_i),
        .rvalid (bus.rvalid_i)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          epoch = 0;
    int          lat = 1;
    bit          gnt_en = 1'b0;
    int          dut_grants = 0;
    logic [31:0] exp_pc = RESET_PC;
    resp_t       busq[$];
    ent_t        expq[$];

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    // One clock cycle: drive bus, check outputs against the model, advance.
    task automatic cycle();
        bit    rv;
        bit    fl;
        bit    exp_req;
        resp_t r;
        ent_t  e;
        rv = (busq.size() > 0) && (busq[0].due <= cyc);
        bus.rvalid_i = rv;
        bus.rdata_i  = rv ? mkdata(busq[0].addr) : 32'hDEAD_BEEF;
        bus.gnt_i    = gnt_en;
        #1;
        fl      = bus.flush_i;
        exp_req = !fl && ((expq.size() + busq.size()) < DEPTH);
        chk("req_o", 64'(bus.req_o), 64'(exp_req));
        if (bus.req_o) chk("addr_o", 64'(bus.addr_o), 64'(exp_pc));
        if (bus.req_o && bus.gnt_i) dut_grants++;
        chk("inst_valid_o", 64'(bus.inst_valid_o), 64'(expq.size() > 0));
        if (expq.size() > 0) begin
            chk("inst_addr_o", 64'(bus.inst_addr_o), 64'(expq[0].pc));
            chk("inst_o", 64'(bus.inst_o), 64'(expq[0].inst));
        end else begin
            chk("inst_addr_o_empty", 64'(bus.inst_addr_o), 64'(32'h0));
            chk("inst_o_empty", 64'(bus.inst_o), 64'(NOP));
        end
        if ((expq.size() > 0) && !bus.hold_i && !fl) void'(expq.pop_front());
        if (rv) begin
            if ((busq[0].epoch == epoch) && !fl) begin
                e.pc   = busq[0].addr;
                e.inst = mkdata(busq[0].addr);
                expq.push_back(e);
            end
            void'(busq.pop_front());
        end
        if (exp_req && gnt_en) begin
            r.addr   = exp_pc;
            r.due    = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
            r.epoch  = epoch;
            last_due = r.due;
            busq.push_back(r);
            exp_pc   = exp_pc + 32'd4;
        end
        if (fl) begin
            expq.delete();
            epoch++;
            exp_pc = bus.flush_addr_i;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst              = 1'b0;
        bus.flush_i      = 1'b0;
        bus.flush_addr_i = 32'h0;
        bus.hold_i       = 1'b0;
        bus.gnt_i        = 1'b0;
        bus.rvalid_i     = 1'b0;
        bus.rdata_i      = 32'h0;
        #2;
        chk("reset_req_o", 64'(bus.req_o), 64'(1'b0));
        chk("reset_inst_valid_o", 64'(bus.inst_valid_o), 64'(1'b0));
        chk("reset_inst_o", 64'(bus.inst_o), 64'(NOP));
        chk("reset_inst_addr_o", 64'(bus.inst_addr_o), 64'(32'h0));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Streaming: grant every cycle, 1-cycle response.
        gnt_en = 1'b1;
        lat    = 1;
        repeat (12) cycle();

        // Drain, retarget to 0, then hold with a zero-wait bus.
        gnt_en = 1'b0;
        repeat (6) cycle();
        bus.flush_i      = 1'b1;
        bus.flush_addr_i = 32'h0;
        cycle();
        bus.flush_i = 1'b0;
        repeat (2) cycle();
        bus.hold_i = 1'b1;
        gnt_en     = 1'b1;
        dut_grants = 0;
        repeat (10) cycle();
        chk("hold_grants", 64'(dut_grants), 64'(DEPTH));
        bus.hold_i = 1'b0;
        gnt_en     = 1'b0;
        repeat (6) cycle();

        // Flush with two responses still pending.
        lat    = 4;
        gnt_en = 1'b1;
        repeat (2) cycle();
        bus.flush_i      = 1'b1;
        bus.flush_addr_i = 32'h100;
        cycle();
        bus.flush_i = 1'b0;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            #1;
            if (bus.inst_valid_o) begin
                chk("post_flush_pc", 64'(bus.inst_addr_o), 64'(32'h100));
                seen = 1'b1;
            end
            cycle();
        end
        chk("post_flush_seen", 64'(seen), 64'(1'b1));

        // Flush against a full FIFO while hold is asserted.
        bus.hold_i = 1'b1;
        repeat (8) cycle();
        bus.flush_i      = 1'b1;
        bus.flush_addr_i = 32'h200;
        cycle();
        bus.flush_i = 1'b0;
        bus.hold_i  = 1'b0;
        repeat (6) cycle();

        // Flush in the same cycle a response returns.
        lat = 2;
        repeat (3) cycle();
        for (int i = 0; i < 8 && !((busq.size() > 0) && (busq[0].due <= cyc)); i++) cycle();
        bus.flush_i      = 1'b1;
        bus.flush_addr_i = 32'h300;
        cycle();
        bus.flush_i = 1'b0;
        repeat (3) cycle();
        bus.flush_i      = 1'b1;
        bus.flush_addr_i = 32'h400;
        cycle();
        bus.flush_addr_i = 32'h500;
        cycle();
        bus.flush_i = 1'b0;
        repeat (8) cycle();

        // Asynchronous reset between edges, with a stray response inside reset.
        lat = 1;
        repeat (3) cycle();
        #2;
        rst = 1'b0;
        #1;
        chk("async_req_o", 64'(bus.req_o), 64'(1'b0));
        chk("async_inst_valid_o", 64'(bus.inst_valid_o), 64'(1'b0));
        chk("async_inst_o", 64'(bus.inst_o), 64'(NOP));
        chk("async_inst_addr_o", 64'(bus.inst_addr_o), 64'(32'h0));
        bus.gnt_i    = 1'b0;
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = 32'hBAD0_BAD0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        bus.rvalid_i = 1'b0;
        busq.delete();
        expq.delete();
        exp_pc   = RESET_PC;
        last_due = cyc;
        rst      = 1'b1;
        repeat (6) cycle();

        // Fetch PC wrap at the top of the address space.
        bus.flush_i      = 1'b1;
        bus.flush_addr_i = 32'hFFFF_FFF8;
        cycle();
        bus.flush_i = 1'b0;
        repeat (8) cycle();
        gnt_en = 1'b0;
        repeat (4) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
